alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single combinational 32-bit ALU between two requesters (e.g. the execute stage and an address/branch-compare unit). Each requester issues an operand pair plus 4-bit ALU control through a valid/ready handshake. The block registers the winning request, drives the shared ALU, captures the result and zero flag, and returns them on one response channel tagged with the requester ID. One operation is in flight at a time.

---
 rtl/alu_arbiter_if.sv | 50 +++++
 rtl/alu_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Signal bundle between alu_arbiter, its two requesters, the response consumer and the shared ALU.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int CTL_W = 4
) ();
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [CTL_W-1:0] req0_ctl;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [CTL_W-1:0] req1_ctl;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [CTL_W-1:0] alu_ctl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctl,
        input  req1_valid, req1_a, req1_b, req1_ctl,
        input  rsp_ready, alu_result, alu_zero,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero,
        output alu_a, alu_b, alu_ctl, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctl,
        output req1_valid, req1_a, req1_b, req1_ctl,
        output rsp_ready, alu_result, alu_zero,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero,
        input  alu_a, alu_b, alu_ctl, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter that sequences one operation at a time through a shared
// external ALU: accept (IDLE) -> drive ALU (EXEC) -> hold response (RESP).
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CTL_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    logic             last_grant_r;
    logic             grant_vld_s;
    logic             grant_id_s;
    logic             accept_s;

    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic [CTL_W-1:0] op_ctl_s;

    logic [WIDTH-1:0] alu_a_r;
    logic [WIDTH-1:0] alu_b_r;
    logic [CTL_W-1:0] alu_ctl_r;

    logic             rsp_id_r;
    logic [WIDTH-1:0] rsp_result_r;
    logic             rsp_zero_r;
    logic             rsp_valid_r;
    logic             busy_r;

    // Round-robin pick: a lone request wins; on a tie the port not served last wins
    always_comb begin
        grant_vld_s = 1'b0;
        grant_id_s  = 1'b0;
        case ({bus.req1_valid, bus.req0_valid})
            2'b01: begin
                grant_vld_s = 1'b1;
                grant_id_s  = 1'b0;
            end
            2'b10: begin
                grant_vld_s = 1'b1;
                grant_id_s  = 1'b1;
            end
            2'b11: begin
                grant_vld_s = 1'b1;
                grant_id_s  = ~last_grant_r;
            end
            default: begin
                grant_vld_s = 1'b0;
                grant_id_s  = 1'b0;
            end
        endcase
    end

    // Accept only in IDLE; the reset cycle never accepts so no requester sees a phantom handshake
    always_comb begin
        accept_s = 1'b0;
        if ((state_r == ST_IDLE) && !reset) begin
            accept_s = grant_vld_s;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Operand steering from the granted port
    always_comb begin
        op_a_s   = bus.req0_a;
        op_b_s   = bus.req0_b;
        op_ctl_s = bus.req0_ctl;
        if (grant_id_s) begin
            op_a_s   = bus.req1_a;
            op_b_s   = bus.req1_b;
            op_ctl_s = bus.req1_ctl;
        end else begin
            op_a_s   = bus.req0_a;
            op_b_s   = bus.req0_b;
            op_ctl_s = bus.req0_ctl;
        end
    end

    // Sequencer next-state: EXEC lasts exactly one cycle, RESP waits for the consumer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request capture: ALU operand registers, owner tag and round-robin history
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a_r      <= {WIDTH{1'b0}};
            alu_b_r      <= {WIDTH{1'b0}};
            alu_ctl_r    <= {CTL_W{1'b0}};
            rsp_id_r     <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            alu_a_r      <= op_a_s;
            alu_b_r      <= op_b_s;
            alu_ctl_r    <= op_ctl_s;
            rsp_id_r     <= grant_id_s;
            last_grant_r <= grant_id_s;
        end
    end

    // Result capture at the end of EXEC; held untouched through RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_result_r <= {WIDTH{1'b0}};
            rsp_zero_r   <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            rsp_result_r <= bus.alu_result;
            rsp_zero_r   <= bus.alu_zero;
        end
    end

    // Status flags registered from the next state so they line up with the state register
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    assign bus.req0_ready = accept_s & ~grant_id_s;
    assign bus.req1_ready = accept_s &  grant_id_s;

    assign bus.alu_a      = alu_a_r;
    assign bus.alu_b      = alu_b_r;
    assign bus.alu_ctl    = alu_ctl_r;

    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_zero   = rsp_zero_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: models the shared ALU, keeps a response scoreboard,
// runs a table of single operations and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int WIDTH = 32;
    localparam int CTL_W = 4;

    logic clk = 1'b0;
    logic reset;

    alu_arbiter_if #(.WIDTH(WIDTH), .CTL_W(CTL_W)) bus ();

    alu_arbiter #(.WIDTH(WIDTH), .CTL_W(CTL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference ALU: {zero, result}; zero only for SUB with equal operands
    function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] ctl);
        logic [31:0] r;
        case (ctl)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0110: r = a - b;
            default: r = a + b;
        endcase
        return {(ctl == 4'b0110) && (r == 32'd0), r};
    endfunction

    assign {bus.alu_zero, bus.alu_result} = alu_model(bus.alu_a, bus.alu_b, bus.alu_ctl);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        id;
        logic [31:0] result;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    logic rsp_ids[$];
    int   rsp_count = 0;
    int   acc_count = 0;

    // Scoreboard: push on accept, pop and compare on response handshake, flush on reset
    always @(negedge clk) begin
        exp_t        e;
        logic [32:0] m;
        if (reset) begin
            sb.delete();
        end else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_count++;
                rsp_ids.push_back(bus.rsp_id);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: response id %0d result 0x%0h, expected none",
                             bus.rsp_id, bus.rsp_result);
                end else begin
                    e = sb.pop_front();
                    chk("sb_id", bus.rsp_id, e.id);
                    chk("sb_result", bus.rsp_result, e.result);
                    chk("sb_zero", bus.rsp_zero, e.zero);
                end
            end
            if (bus.req0_valid && bus.req0_ready) begin
                m = alu_model(bus.req0_a, bus.req0_b, bus.req0_ctl);
                sb.push_back('{1'b0, m[31:0], m[32]});
                acc_count++;
            end
            if (bus.req1_valid && bus.req1_ready) begin
                m = alu_model(bus.req1_a, bus.req1_b, bus.req1_ctl);
                sb.push_back('{1'b1, m[31:0], m[32]});
                acc_count++;
            end
        end
    end

    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [31:0] exp_result;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[8];

    task automatic drive(input logic port, input logic vld, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] ctl);
        if (port) begin
            bus.req1_valid = vld; bus.req1_a = a; bus.req1_b = b; bus.req1_ctl = ctl;
        end else begin
            bus.req0_valid = vld; bus.req0_a = a; bus.req0_b = b; bus.req0_ctl = ctl;
        end
    endtask

    // Waits (at negedges) for the port's ready; returns at the accepting cycle's negedge
    task automatic wait_ready(input logic port, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(port ? bus.req1_ready : bus.req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < 20), 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(posedge clk); #1;
        drive(v.port, 1'b1, v.a, v.b, v.ctl);
        wait_ready(v.port, $sformatf("v%0d_accept", idx));
        @(posedge clk); #1;
        drive(v.port, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        chk($sformatf("v%0d_exec_busy", idx), bus.busy, 1'b1);
        chk($sformatf("v%0d_exec_rsp_valid", idx), bus.rsp_valid, 1'b0);
        chk($sformatf("v%0d_alu_a", idx), bus.alu_a, v.a);
        chk($sformatf("v%0d_alu_b", idx), bus.alu_b, v.b);
        chk($sformatf("v%0d_alu_ctl", idx), bus.alu_ctl, v.ctl);
        @(negedge clk);
        chk($sformatf("v%0d_rsp_valid", idx), bus.rsp_valid, 1'b1);
        chk($sformatf("v%0d_rsp_id", idx), bus.rsp_id, v.port);
        chk($sformatf("v%0d_rsp_result", idx), bus.rsp_result, v.exp_result);
        chk($sformatf("v%0d_rsp_zero", idx), bus.rsp_zero, v.exp_zero);
        @(negedge clk);
        chk($sformatf("v%0d_idle_rsp_valid", idx), bus.rsp_valid, 1'b0);
        chk($sformatf("v%0d_idle_busy", idx), bus.busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        vecs[0] = '{1'b0, 32'd5,          32'd7,    4'b0010, 32'd12,         1'b0};
        vecs[1] = '{1'b1, 32'd9,          32'd9,    4'b0110, 32'd0,          1'b1};
        vecs[2] = '{1'b0, 32'd3,          32'd5,    4'b0110, 32'hFFFF_FFFE,  1'b0};
        vecs[3] = '{1'b1, 32'h0000_00F0,  32'h0F,   4'b0000, 32'd0,          1'b0};
        vecs[4] = '{1'b0, 32'h0000_00F0,  32'h0F,   4'b0001, 32'h0000_00FF,  1'b0};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF,  32'd1,    4'b0010, 32'd0,          1'b0};
        vecs[6] = '{1'b0, 32'd10,         32'd20,   4'b1111, 32'd30,         1'b0};
        vecs[7] = '{1'b1, 32'd100,        32'd1,    4'b0111, 32'd101,        1'b0};

        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        drive(1'b0, 1'b1, 32'h0000_00F0, 32'h0000_003C, 4'b0000);
        drive(1'b1, 1'b1, 32'h0000_00F0, 32'h0000_000F, 4'b0001);

        // Reset values, with both requests pending during reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", bus.req0_ready, 1'b0);
        chk("rst_req1_ready", bus.req1_ready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rsp_id", bus.rsp_id, 1'b0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);
        chk("rst_rsp_zero", bus.rsp_zero, 1'b0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_b", bus.alu_b, 32'd0);
        chk("rst_alu_ctl", bus.alu_ctl, 4'd0);
        chk("rst_no_accept", acc_count, 32'd0);

        // Simultaneous first requests: port 0 first, port 1 three cycles later
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("tie_c0_ready0", bus.req0_ready, 1'b1);
        chk("tie_c0_ready1", bus.req1_ready, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        chk("tie_c1_busy", bus.busy, 1'b1);
        chk("tie_c1_ready1", bus.req1_ready, 1'b0);
        chk("tie_c1_alu_a", bus.alu_a, 32'h0000_00F0);
        chk("tie_c1_alu_b", bus.alu_b, 32'h0000_003C);
        @(negedge clk);
        chk("tie_c2_rsp_valid", bus.rsp_valid, 1'b1);
        chk("tie_c2_rsp_id", bus.rsp_id, 1'b0);
        chk("tie_c2_rsp_result", bus.rsp_result, 32'h0000_0030);
        chk("tie_c2_ready1", bus.req1_ready, 1'b0);
        @(negedge clk);
        chk("tie_c3_rsp_valid", bus.rsp_valid, 1'b0);
        chk("tie_c3_ready1", bus.req1_ready, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        chk("tie_c4_busy", bus.busy, 1'b1);
        @(negedge clk);
        chk("tie_c5_rsp_valid", bus.rsp_valid, 1'b1);
        chk("tie_c5_rsp_id", bus.rsp_id, 1'b1);
        chk("tie_c5_rsp_result", bus.rsp_result, 32'h0000_00FF);
        @(negedge clk);
        chk("tie_c6_busy", bus.busy, 1'b0);

        // Table of single operations
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Back-pressure with a second request held pending
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_1234, 32'h0000_0034, 4'b0110);
        wait_ready(1'b1, "bp_accept");
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b0, 1'b1, 32'd2, 32'd3, 4'b0010);
        @(negedge clk);
        chk("bp_exec_ready0", bus.req0_ready, 1'b0);
        @(negedge clk);
        base = rsp_count;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("bp%0d_rsp_valid", i), bus.rsp_valid, 1'b1);
            chk($sformatf("bp%0d_rsp_id", i), bus.rsp_id, 1'b1);
            chk($sformatf("bp%0d_rsp_result", i), bus.rsp_result, 32'h0000_1200);
            chk($sformatf("bp%0d_rsp_zero", i), bus.rsp_zero, 1'b0);
            chk($sformatf("bp%0d_ready0", i), bus.req0_ready, 1'b0);
            chk($sformatf("bp%0d_busy", i), bus.busy, 1'b1);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_one_handshake", rsp_count, base + 1);
        chk("bp_idle_rsp_valid", bus.rsp_valid, 1'b0);
        chk("bp_held_req_ready0", bus.req0_ready, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        chk("bp_held_rsp_valid", bus.rsp_valid, 1'b1);
        chk("bp_held_rsp_result", bus.rsp_result, 32'd5);
        @(negedge clk);
        chk("bp_total_handshakes", rsp_count, base + 2);

        // Reset during EXEC drops the op; then continuous ties alternate starting with port 0
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 32'h0000_0055, 32'h0000_0011, 4'b0010);
        wait_ready(1'b0, "rst_mid_accept");
        base = rsp_count;
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010);
        drive(1'b1, 1'b1, 32'd7, 32'd2, 4'b0110);
        @(negedge clk);
        chk("rst_mid_busy_exec", bus.busy, 1'b1);
        chk("rst_mid_ready0", bus.req0_ready, 1'b0);
        chk("rst_mid_ready1", bus.req1_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        acc_count = 0;
        rsp_ids.delete();
        @(negedge clk);
        chk("rst_mid_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_mid_busy", bus.busy, 1'b0);
        chk("rst_mid_alu_a", bus.alu_a, 32'd0);
        chk("rst_mid_tie_ready0", bus.req0_ready, 1'b1);
        chk("rst_mid_tie_ready1", bus.req1_ready, 1'b0);
        n = 0;
        while (acc_count < 8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        chk("fair_accepts", acc_count, 32'd8);
        n = 0;
        while (rsp_ids.size() < 8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("fair_rsp_count", rsp_ids.size(), 32'd8);
        chk("rst_mid_no_stale_rsp", rsp_count, base + 8);
        for (int i = 0; i < 8; i++) begin
            if (i < rsp_ids.size()) begin
                chk($sformatf("fair_id%0d", i), rsp_ids[i], i[0]);
            end else begin
                chk($sformatf("fair_id%0d_missing", i), 1'b0, 1'b1);
            end
        end

        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
